pwm_capture: RTL and testbench
==============================

# pwm_capture

Receive-side counterpart of the motor PWM generator. Measures one PWM waveform (such as a motor enable line) and reports three values: period in clocks, high time in clocks, and the 10-bit duty value the generator was driven with. The block sits on the bench and on on-board feedback paths to check the motor drive closed-loop. Duty is recovered as floor(high*1024/period) by an iterative divider, so no combinational divide is used.

## Interface
- CNT_W, 32: width of the period/high-time counters and outputs.
- TIMEOUT, 100_000: clocks without an expected edge before the input is declared static (1 ms at 100 MHz).
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM input.
- duty  output  10  recovered duty, 0..1023.
- period  output  CNT_W  rising-to-rising interval in clocks.
- high_time  output  CNT_W  rising-to-falling interval in clocks.
- valid  output  1  one-cycle pulse when duty/period/high_time update.
- stuck_high  output  1  level; input has been static high for TIMEOUT clocks.
- stuck_low  output  1  level; input has been static low for TIMEOUT clocks, or no edge has been seen since reset.
- overrun  output  1  one-cycle pulse; a completed measurement was dropped because the divider was busy.

## Operation
- Input path: 2-flop synchronizer, reset value 0, then a delay flop. rise = s & ~d, fall = ~s & d. The fixed latency cancels in every measurement.
- Counter cnt:
  - Loads 1 on the rise cycle, otherwise increments.
  - Saturates at TIMEOUT.
- Capture FSM states:
  - WAIT_RISE: reset state; ignores fall.
  - HIGH: on fall, high_cap <= cnt, go to LOW.
  - LOW: on rise, period_cap <= cnt, issue a job to the divider, go to HIGH.
  - A rise in WAIT_RISE goes to HIGH without a job, because the first period is incomplete.
- Timeout:
  - In HIGH with cnt == TIMEOUT: duty=1023, high_time=period=0, valid pulse, stuck_high=1, go to WAIT_RISE.
  - In LOW or WAIT_RISE with cnt == TIMEOUT: duty=0, high_time=period=0, valid pulse, stuck_low=1, stay in or go to WAIT_RISE.
  - A timeout fires once per static interval; no repeat pulses while cnt stays saturated.
  - stuck_* clear on the next rise.
- Divider states IDLE -> RUN (10 iterations) -> DONE:
  - Operands are latched at job issue: rem = high_cap (CNT_W+1 bits), den = period_cap.
  - Each iteration: rem = 2*rem; if rem >= den then rem -= den and shift in 1, else shift in 0.
  - The 10 shifted-in bits form q. high_cap < period_cap always holds, so q fits in 10 bits.
  - DONE: duty <= q, period <= den, high_time <= the latched high operand, valid pulse. Go to IDLE.
- Divider busy:
  - A job issued while the divider is not IDLE is discarded and overrun pulses. Outputs are not disturbed.
  - A job in the same cycle as DONE is also discarded.
- Simultaneous events: a timeout and a divider DONE in the same cycle are resolved as follows.
  - The divider result is written first.
  - The timeout result is written the following cycle.
  - This produces two valid pulses.
- Reset mid-operation: all state is cleared immediately and any in-flight job is lost.
- Reset values:
  - duty=0, period=0, high_time=0, valid=0, overrun=0, stuck_high=0.
  - stuck_low=1.
  - FSMs in WAIT_RISE and IDLE, cnt=0.

## Timing
- Rise/fall are detected 3 clk edges after the pin transition.
- period and high_time are exact clock counts.
- valid rises 11 clocks after the rise-detection clock that closes a period: 1 cycle to issue, 10 iterations, registered output.
- Minimum period without overrun: 12 clocks.
- Shortest measurable high or low phase: 1 clock.

## Test plan
- Generator at 100 MHz, freq 25000, duty 750 (high 2929 clk, period 4001 clk) -> from the second full period on, valid every 4001 clk with period=4001, high_time=2929, duty=749, overrun never asserted.
- Duty 0 (static low), TIMEOUT=10000 -> stuck_low stays 1 from reset, and exactly one valid pulse occurs with duty=0 when cnt saturates.
- Input held high after three 4001-clk periods, TIMEOUT=10000 -> one valid pulse with duty=1023 and stuck_high=1 10000 clk after the last rise; both clear on the next rise.
- Period 8 clk, high 3 clk -> overrun pulses. Every delivered result is period=8, high_time=3, duty=384.
- Assert rst during divider RUN -> all outputs return to reset values the same cycle, and no valid pulse follows the release.
- Duty stepped 750 -> 256 mid-stream -> each output set matches the period it measured, with no mixed high/period values. After the step: high_time=1000 and duty=255.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of one PWM input.
// Edges are detected on a synchronized copy of the pin. A free-running
// saturating counter times each phase. Duty is recovered as
// floor(high*1024/period) by a 10-step restoring divider. Static inputs
// are reported through a single timeout result per static interval.
module pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [9:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_WAIT_RISE, ST_HIGH, ST_LOW} cap_state_t;
  typedef enum logic [1:0] {DV_IDLE, DV_RUN, DV_DONE} div_state_t;

  // Input path and phase counter
  logic             r_sync1, r_sync2, r_dly;
  logic             w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt;

  // Capture FSM
  cap_state_t       r_cap_state;
  logic [CNT_W-1:0] r_high_cap;
  logic             r_to_fired;
  logic             r_stuck_high, r_stuck_low;
  logic             w_job, w_to_fire, w_to_kind_high;

  // Divider
  div_state_t       r_div_state;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_den;
  logic [CNT_W-1:0] r_hi_op;
  logic [9:0]       r_quo;
  logic [3:0]       r_iter;
  logic             r_overrun;
  logic [CNT_W:0]   w_rem_sh;
  logic             w_ge;

  // Output registers
  logic [9:0]       r_duty;
  logic [CNT_W-1:0] r_period, r_high_time;
  logic             r_valid;
  logic             r_to_pend, r_pend_high;

  assign w_rise = r_sync2 & ~r_dly;
  assign w_fall = ~r_sync2 & r_dly;

  // A job closes a full period: rise seen while waiting in the low phase.
  assign w_job = (r_cap_state == ST_LOW) && w_rise;

  // Timeout fires once when the counter reaches its limit, unless an
  // edge is being handled in the same cycle.
  assign w_to_fire = (r_cnt == TO_VAL) && !r_to_fired && !w_rise &&
                     !((r_cap_state == ST_HIGH) && w_fall);
  assign w_to_kind_high = (r_cap_state == ST_HIGH);

  // The remainder is always below the divisor, so only the doubled value
  // needs the extra bit.
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_ge     = (w_rem_sh >= {1'b0, r_den});

  // Two-flop synchronizer followed by a delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // Phase counter: restarts at 1 on each rise, saturates at the timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != TO_VAL) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture FSM: tracks phases, captures high time, flags static input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_state  <= ST_WAIT_RISE;
      r_high_cap   <= '0;
      r_to_fired   <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b1;
    end else if (w_rise) begin
      r_cap_state  <= ST_HIGH;
      r_to_fired   <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else if ((r_cap_state == ST_HIGH) && w_fall) begin
      r_high_cap  <= r_cnt;
      r_cap_state <= ST_LOW;
    end else if (w_to_fire) begin
      r_to_fired  <= 1'b1;
      r_cap_state <= ST_WAIT_RISE;
      if (w_to_kind_high) begin
        r_stuck_high <= 1'b1;
      end else begin
        r_stuck_low <= 1'b1;
      end
    end
  end

  // Restoring divider: latches operands on a job, 10 iterations, then DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_state <= DV_IDLE;
      r_rem       <= '0;
      r_den       <= '0;
      r_hi_op     <= '0;
      r_quo       <= '0;
      r_iter      <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_job && (r_div_state != DV_IDLE);
      case (r_div_state)
        DV_IDLE: begin
          if (w_job) begin
            r_rem       <= r_high_cap;
            r_den       <= r_cnt;
            r_hi_op     <= r_high_cap;
            r_quo       <= '0;
            r_iter      <= '0;
            r_div_state <= DV_RUN;
          end
        end
        DV_RUN: begin
          if (w_ge) begin
            r_rem <= CNT_W'(w_rem_sh - {1'b0, r_den});
          end else begin
            r_rem <= w_rem_sh[CNT_W-1:0];
          end
          r_quo  <= {r_quo[8:0], w_ge};
          r_iter <= r_iter + 4'd1;
          if (r_iter == 4'd9) begin
            r_div_state <= DV_DONE;
          end
        end
        DV_DONE: begin
          r_div_state <= DV_IDLE;
        end
        default: begin
          r_div_state <= DV_IDLE;
        end
      endcase
    end
  end

  // Result registers: divider result wins a collision, timeout follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_to_pend   <= 1'b0;
      r_pend_high <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_div_state == DV_DONE) begin
        r_duty      <= r_quo;
        r_period    <= r_den;
        r_high_time <= r_hi_op;
        r_valid     <= 1'b1;
        r_to_pend   <= w_to_fire;
        r_pend_high <= w_to_kind_high;
      end else if (r_to_pend || w_to_fire) begin
        r_duty      <= (r_to_pend ? r_pend_high : w_to_kind_high) ? 10'd1023 : 10'd0;
        r_period    <= '0;
        r_high_time <= '0;
        r_valid     <= 1'b1;
        r_to_pend   <= 1'b0;
      end
    end
  end

  assign duty       = r_duty;
  assign period     = r_period;
  assign high_time  = r_high_time;
  assign valid      = r_valid;
  assign stuck_high = r_stuck_high;
  assign stuck_low  = r_stuck_low;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven duty vectors, randomized waveforms
// against an event-level reference model, and hand-written sequences for
// timeouts, overrun and reset during a divide.
module tb_pwm_capture;

  localparam int T = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [9:0]  duty;
  logic [31:0] period, high_time;
  logic        valid, stuck_high, stuck_low, overrun;

  pwm_capture #(.CNT_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty(duty), .period(period), .high_time(high_time),
    .valid(valid), .stuck_high(stuck_high), .stuck_low(stuck_low),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { longint t; longint p; longint h; longint d; } res_t;
  typedef struct { int h; int l; int d; } vec_t;

  res_t   exp_q[$];
  longint ovr_q[$];
  longint cyc = 0;
  int     n_checks = 0, n_pass = 0;
  int     n_valid = 0, n_ovr = 0;
  longint last_p = 0, last_h = 0, last_d = 0;

  // reference model state: last rise/fall pin cycles, armed = a rise has
  // been seen since reset/timeout, acc = detection cycle of last accepted job
  bit     pin_cur = 1'b0;
  bit     m_armed = 1'b0, m_fell = 1'b0;
  longint m_rise = 0, m_fall = 0, m_acc = -1000;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // one clock; sample #1 after the edge and score valid/overrun events
  task automatic tick();
    res_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
      e = exp_q.pop_front();
      chk("valid_missing", cyc, e.t);
    end
    while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
      chk("overrun_missing", cyc, ovr_q.pop_front());
    end
    if (valid) begin
      n_valid++;
      last_p = period; last_h = high_time; last_d = duty;
      if (exp_q.size() == 0) chk("valid_unexpected", valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("valid_time", cyc, e.t);
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("duty", duty, e.d);
      end
    end
    if (overrun) begin
      n_ovr++;
      if (ovr_q.size() == 0) chk("overrun_unexpected", overrun, 0);
      else chk("overrun_time", cyc, ovr_q.pop_front());
    end
  endtask

  // pin rise driven after edge c is detected at edge c+3; a complete
  // period yields a result 11 clocks later unless the previous accepted
  // job began fewer than 12 clocks earlier, in which case overrun pulses
  task automatic model_rise(input longint c);
    res_t   e;
    longint r;
    r = c + 3;
    if (m_armed && m_fell) begin
      e.p = c - m_rise;
      e.h = m_fall - m_rise;
      if (r - m_acc >= 12) begin
        e.t = r + 11;
        e.d = (e.h * 1024) / e.p;
        exp_q.push_back(e);
        m_acc = r;
      end else begin
        ovr_q.push_back(r);
      end
    end
    m_armed = 1'b1;
    m_fell  = 1'b0;
    m_rise  = c;
  endtask

  task automatic model_fall(input longint c);
    if (m_armed) begin
      m_fall = c;
      m_fell = 1'b1;
    end
  endtask

  task automatic set_pin(input bit v, input int n);
    if (v && !pin_cur) model_rise(cyc);
    else if (!v && pin_cur) model_fall(cyc);
    pin_cur = v;
    pwm_in  = v;
    repeat (n) tick();
  endtask

  initial begin
    vec_t   tbl[8];
    res_t   e;
    longint r0, rr;
    int     v0, o0, bad;

    tbl[0] = '{6, 10, 384};
    tbl[1] = '{1, 15, 64};
    tbl[2] = '{15, 1, 960};
    tbl[3] = '{5, 15, 256};
    tbl[4] = '{100, 900, 102};
    tbl[5] = '{333, 667, 340};
    tbl[6] = '{2929, 1072, 749};
    tbl[7] = '{1000, 3001, 255};

    // reset state
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    r0 = cyc;
    chk("rst_duty", duty, 0);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_stuck_high", stuck_high, 0);
    chk("rst_stuck_low", stuck_low, 1);

    // static low from reset: one timeout result when the counter saturates
    e = '{r0 + T + 1, 0, 0, 0};
    exp_q.push_back(e);
    v0 = n_valid;
    bad = 0;
    repeat (T + 20) begin
      tick();
      if (!stuck_low) bad++;
    end
    chk("stuck_low_static_cycles_low", bad, 0);
    chk("static_low_valid_count", n_valid - v0, 1);

    // table-driven duty vectors, three periods each
    o0 = n_ovr;
    for (int i = 0; i < 8; i++) begin
      repeat (3) begin
        set_pin(1'b1, tbl[i].h);
        set_pin(1'b0, tbl[i].l);
      end
      chk("tbl_period", last_p, tbl[i].h + tbl[i].l);
      chk("tbl_high_time", last_h, tbl[i].h);
      chk("tbl_duty", last_d, tbl[i].d);
    end
    chk("tbl_overrun_count", n_ovr - o0, 0);
    chk("stuck_low_cleared", stuck_low, 0);

    // 8-clock period: divider busy, overrun expected
    o0 = n_ovr;
    repeat (10) begin
      set_pin(1'b1, 3);
      set_pin(1'b0, 5);
    end
    chk("ovr_seen", (n_ovr - o0) > 0, 1);
    chk("ovr_last_period", last_p, 8);
    chk("ovr_last_high", last_h, 3);
    chk("ovr_last_duty", last_d, 384);

    // randomized waveforms against the model
    repeat (150) begin
      set_pin(1'b1, int'($urandom_range(1, 20)));
      set_pin(1'b0, int'($urandom_range(1, 20)));
    end

    // held high after three periods: stuck_high timeout
    repeat (3) begin
      set_pin(1'b1, 30);
      set_pin(1'b0, 20);
    end
    set_pin(1'b1, 0);
    rr = cyc + 3;
    e = '{rr + T, 0, 0, 1023};
    exp_q.push_back(e);
    m_armed = 1'b0;
    bad = 0;
    repeat (T + 4) begin
      tick();
      if (stuck_high != (cyc >= rr + T)) bad++;
    end
    chk("stuck_high_timing_errors", bad, 0);
    chk("stuck_high_set", stuck_high, 1);
    chk("stuck_high_duty", duty, 1023);
    chk("stuck_high_period", period, 0);
    set_pin(1'b0, 5);
    set_pin(1'b1, 5);
    chk("stuck_high_cleared", stuck_high, 0);
    chk("stuck_low_after_rise", stuck_low, 0);
    chk("queue_drained", exp_q.size() + ovr_q.size(), 0);

    // reset while the divider is running
    set_pin(1'b1, 5);
    set_pin(1'b0, 10);
    set_pin(1'b1, 10);
    set_pin(1'b0, 10);
    chk("pre_reset_duty", duty, 512);
    set_pin(1'b1, 7);
    rst = 1'b1;
    #1;
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_stuck_low", stuck_low, 1);
    chk("mid_rst_stuck_high", stuck_high, 0);
    chk("mid_rst_valid", valid, 0);
    exp_q.delete();
    ovr_q.delete();
    m_armed = 1'b0;
    m_fell  = 1'b0;
    m_acc   = -1000;
    pwm_in  = 1'b0;
    pin_cur = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    v0 = n_valid;
    repeat (30) tick();
    chk("no_valid_after_reset", n_valid - v0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
